anfsqrt_pdm_341449297858921043: RTL and testbench
=================================================

// Module: anfsqrt_pdm_341449297858921043
// PURPOSE
//  Downstream stage of the iterative sqrt core: converts its 7-bit result into a first-order
//  pulse-density bitstream for io_out[0] (true) and io_out[1] (complement).
//  New results are double-buffered and take effect only on a PDM frame boundary, so the
//  ones-density of every frame is exact and glitch-free.
// PARAMETERS
//  W      7   data width; result width and PDM frame length 2**W cycles
//  LFSR_W 8   dither LFSR width (used only when ANFSQRT_PDM_DITHER_EN is defined)
// PORTS
//  clk         in   1  rising-edge clock, same clock as the sqrt core
//  rst_n       in   1  asynchronous active-low reset
//  result      in   W  sqrt result word from the core's result register
//  result_vld  in   1  1-cycle strobe: result holds a new word; sampled on this edge
//  pdm_out     out  1  registered PDM bit
//  pdm_out_n   out  1  registered complement of pdm_out, same edge
//  level       out  W  level currently being modulated
//  frame_start out  1  1-cycle pulse on the first cycle of each frame
//  overrun     out  1  1-cycle pulse: a pending word was overwritten before use
// BEHAVIOUR
//  Reset (async assert, sync release): frame_cnt=0, acc=0, level=0, pend=0, pend_full=0,
//   pdm_out=0, pdm_out_n=1, frame_start=0, overrun=0, lfsr=LFSR_W'h01.
//  frame_cnt: W-bit up-counter, +1 every cycle, wraps 2**W-1 -> 0. wrap = (frame_cnt==2**W-1).
//  Capture: on result_vld, pend<=result and pend_full<=1.
//   If pend_full was already 1 and this is not a wrap cycle: overrun=1 next cycle; newest word wins.
//  Frame boundary (wrap cycle):
//   If pend_full: level<=pend, pend_full<=0.
//   If result_vld coincides with wrap: the incoming word bypasses pend, level<=result,
//    pend_full<=0, no overrun.
//   frame_start=1 on the following cycle (frame_cnt==0).
//  Modulator: {carry,acc_nxt} = acc + level_eff, computed at W+1 bits; acc<=acc_nxt; pdm_out<=carry.
//   level_eff = level (no dither). Constant level L over a full frame -> exactly L ones in 2**W cycles.
//   L=0 -> all zeros; L=2**W-1 -> one zero per frame. acc is never cleared by a level change.
//  Latency: result_vld to first modulated bit = cycles to the next wrap + 1 (2..2**W+1).
//  Upstream cadence (one word per 8 cycles) is faster than the frame, so overruns are
//   expected and benign; the latest word is always applied.
//  Reset mid-frame: all state returns to reset values immediately; pend is discarded.
// CONFIGURATION
//  ANFSQRT_PDM_DITHER_EN defined:
//   Galois LFSR, taps x^8+x^6+x^5+x^4+1, advances once per frame (on wrap).
//   level_eff = min(level + lfsr[0], 2**W-1), saturating, held for the whole frame.
//   Per-frame ones count is L or L+1 (capped at 2**W-1).
//  Not defined: no LFSR flops; level_eff = level exactly.
// TESTING
//  T1 Reset: rst_n=0 mid-run -> pdm_out=0, pdm_out_n=1, level=0, no pulses; hold 3 frames -> all pdm_out=0.
//  T2 Density: vld result=64, wait one boundary -> next 128 cycles contain exactly 64 ones, strictly alternating;
//     repeat for 1, 127 -> 1 and 127 ones; pdm_out_n == ~pdm_out every cycle.
//  T3 Boundary hold: vld result=10 at frame_cnt=5 -> level stays old until frame_cnt wraps;
//     level=10 at frame_cnt=0; frame_start pulses at that cycle.
//  T4 Overrun: vld 20 at cnt=8, vld 30 at cnt=16 -> overrun pulse at cnt=17; level=30 next frame.
//  T5 Coincidence: vld 99 exactly on wrap cycle with pend_full=1 (pend=40) -> level=99, no overrun, pend_full=0.
//  T6 Dither (macro on): level=127 -> ones count never exceeds 127 per frame; level=0 -> counts in {0,1},
//     sequence matches reference LFSR model seeded 0x01.

Source files
------------

// File: rtl/anfsqrt_pdm_341449297858921043_if.sv
// anfsqrt_pdm_341449297858921043_if
//   Bundles the sqrt-core result handshake and the PDM-side outputs.
//   master: the result producer / observer of the modulator outputs.
//   slave : the PDM stage itself.
interface anfsqrt_pdm_341449297858921043_if #(
   parameter int W = 7
);
   logic [W-1:0] result;
   logic         result_vld;
   logic         pdm_out;
   logic         pdm_out_n;
   logic [W-1:0] level;
   logic         frame_start;
   logic         overrun;

   modport master (
      output result, result_vld,
      input  pdm_out, pdm_out_n, level, frame_start, overrun
   );

   modport slave (
      input  result, result_vld,
      output pdm_out, pdm_out_n, level, frame_start, overrun
   );
endinterface

// File: rtl/anfsqrt_pdm_341449297858921043.sv
// anfsqrt_pdm_341449297858921043
//   First-order PDM stage behind the iterative sqrt core. A new W-bit result is
//   parked in a one-word buffer and only becomes the modulated level on a frame
//   boundary (frame = 2**W cycles), so every frame carries an exact ones count.
//   Optional feature macro: ANFSQRT_PDM_DITHER_EN adds a per-frame LFSR dither
//   bit (saturating) on top of the level; without it no LFSR flops exist.
module anfsqrt_pdm_341449297858921043 #(
   parameter int W = 7
`ifdef ANFSQRT_PDM_DITHER_EN
   ,
   parameter int LFSR_W = 8
`endif
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   anfsqrt_pdm_341449297858921043_if.slave         bus
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
   localparam logic [W-1:0] CNT_ONE = W'(1);

   logic [W-1:0] r_frame_cnt;
   logic [W-1:0] r_acc;
   logic [W-1:0] r_level;
   logic [W-1:0] r_pend;
   logic         r_pend_full;
   logic         r_pdm;
   logic         r_pdm_n;
   logic         r_frame_start;
   logic         r_overrun;

   logic         w_wrap;
   logic [W-1:0] w_level_eff;
   logic [W:0]   w_sum;

   assign w_wrap = (r_frame_cnt == CNT_MAX);

`ifdef ANFSQRT_PDM_DITHER_EN
   // Galois form of x^8+x^6+x^5+x^4+1, shifting towards bit 0.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(8'hB8);
   localparam logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(8'h01);

   logic [LFSR_W-1:0] r_lfsr;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      logic [LFSR_W-1:0] n;
      n = s >> 1;
      n = s[0] ? (n ^ LFSR_TAPS) : n;
      return n;
   endfunction

   function automatic logic [W-1:0] sat_add_bit(input logic [W-1:0] a, input logic b);
      logic [W:0] s;
      s = {1'b0, a} + {{W{1'b0}}, b};
      return s[W] ? CNT_MAX : s[W-1:0];
   endfunction

   // Dither LFSR steps once per frame together with the level hand-over.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= LFSR_SEED;
      end else if (w_wrap) begin
         r_lfsr <= lfsr_step(r_lfsr);
      end else begin
         r_lfsr <= r_lfsr;
      end
   end

   assign w_level_eff = sat_add_bit(r_level, r_lfsr[0]);
`else
   // Without dither the modulator follows the buffered level exactly.
   assign w_level_eff = r_level;
`endif

   assign w_sum = {1'b0, r_acc} + {1'b0, w_level_eff};

   // Frame counter, one-word result buffer and hand-over on the wrap cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_cnt   <= '0;
         r_level       <= '0;
         r_pend        <= '0;
         r_pend_full   <= 1'b0;
         r_frame_start <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_frame_cnt   <= r_frame_cnt + CNT_ONE;
         r_frame_start <= w_wrap;
         // A word landing on the wrap cycle goes straight to level, so it never
         // counts as overwriting the buffer.
         r_overrun     <= bus.result_vld & r_pend_full & ~w_wrap;
         if (w_wrap) begin
            r_pend_full <= 1'b0;
            if (bus.result_vld) begin
               r_level <= bus.result;
            end else if (r_pend_full) begin
               r_level <= r_pend;
            end else begin
               r_level <= r_level;
            end
         end else if (bus.result_vld) begin
            r_pend      <= bus.result;
            r_pend_full <= 1'b1;
         end else begin
            r_pend      <= r_pend;
            r_pend_full <= r_pend_full;
         end
      end
   end

   // First-order sigma-delta: carry out of the W-bit accumulator is the PDM bit.
   // The accumulator is deliberately never cleared on a level change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc   <= '0;
         r_pdm   <= 1'b0;
         r_pdm_n <= 1'b1;
      end else begin
         r_acc   <= w_sum[W-1:0];
         r_pdm   <= w_sum[W];
         r_pdm_n <= ~w_sum[W];
      end
   end

   assign bus.pdm_out     = r_pdm;
   assign bus.pdm_out_n   = r_pdm_n;
   assign bus.level       = r_level;
   assign bus.frame_start = r_frame_start;
   assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_anfsqrt_pdm_341449297858921043.sv
// tb_anfsqrt_pdm_341449297858921043
//   Scoreboard bench: the stimulus process pushes the expected frame-boundary
//   and overrun events into queues; a monitor pops them whenever the DUT shows
//   frame_start / overrun, and also checks per-frame ones counts, level hold and
//   the complementary output every cycle.
module tb_anfsqrt_pdm_341449297858921043;
   localparam int W = 7;

   logic clk;
   logic rst_n;

   anfsqrt_pdm_341449297858921043_if #(.W(W)) bus_if ();

   anfsqrt_pdm_341449297858921043 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   typedef struct {
      int    lvl;
      int    ones;
      string name;
   } fs_exp_t;

   typedef struct {
      int    pos;
      string name;
   } ov_exp_t;

   fs_exp_t fs_q[$];
   ov_exp_t ov_q[$];
   int      checks = 0;
   int      errors = 0;
   int      spos   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         if (lo == hi) $display("FAIL %s: got %0d, want %0d", name, act, lo);
         else          $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Upper bound of ones in a frame whose level is l.
   function automatic int ones_hi(input int l);
`ifdef ANFSQRT_PDM_DITHER_EN
      return (l >= 127) ? 127 : l + 1;
`else
      return l;
`endif
   endfunction

   task automatic push_fs(input int lvl, input int ones, input string name);
      fs_exp_t e;
      e.lvl  = lvl;
      e.ones = ones;
      e.name = name;
      fs_q.push_back(e);
   endtask

   task automatic push_ov(input int pos, input string name);
      ov_exp_t e;
      e.pos  = pos;
      e.name = name;
      ov_q.push_back(e);
   endtask

   // Leaves the caller at the falling edge of the frame_cnt==0 cycle.
   task automatic wait_fs();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         seen = bus_if.frame_start;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL frame_start timeout: got none in 300 cycles, want one every 128");
      end
      spos = 0;
   endtask

   // Present word v during the frame_cnt==k cycle.
   task automatic vld_at(input int k, input int v);
      repeat (k - spos) @(posedge clk);
      #1;
      bus_if.result     = v[W-1:0];
      bus_if.result_vld = 1'b1;
      @(posedge clk);
      #1;
      bus_if.result_vld = 1'b0;
      spos = k + 1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " pdm_out"},     int'(bus_if.pdm_out),     0, 0);
      chk({tag, " pdm_out_n"},   int'(bus_if.pdm_out_n),   1, 1);
      chk({tag, " level"},       int'(bus_if.level),       0, 0);
      chk({tag, " frame_start"}, int'(bus_if.frame_start), 0, 0);
      chk({tag, " overrun"},     int'(bus_if.overrun),     0, 0);
   endtask

   // Monitor: consumes expectations when the DUT presents events.
   initial begin : monitor
      int      ones;
      int      pos;
      int      cur_lvl;
      int      prev_pdm;
      fs_exp_t fe;
      ov_exp_t oe;
      ones     = 0;
      pos      = -1;
      cur_lvl  = 0;
      prev_pdm = 0;
      forever begin
         @(negedge clk);
         chk("pdm_out_n complement", int'(bus_if.pdm_out_n), int'(!bus_if.pdm_out), int'(!bus_if.pdm_out));
         if (!rst_n) begin
            ones    = 0;
            pos     = -1;
            cur_lvl = 0;
            chk("reset level",       int'(bus_if.level),       0, 0);
            chk("reset pdm_out",     int'(bus_if.pdm_out),     0, 0);
            chk("reset frame_start", int'(bus_if.frame_start), 0, 0);
            chk("reset overrun",     int'(bus_if.overrun),     0, 0);
         end else begin
            ones += int'(bus_if.pdm_out);
            if (bus_if.frame_start) begin
               pos = 0;
               if (fs_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected frame_start: got pulse, want none queued");
               end else begin
                  fe = fs_q.pop_front();
                  chk({fe.name, " ones in ended frame"}, ones, fe.ones, ones_hi(fe.ones));
                  chk({fe.name, " level at frame start"}, int'(bus_if.level), fe.lvl, fe.lvl);
                  cur_lvl = fe.lvl;
               end
               ones = 0;
            end else begin
               pos++;
            end
            chk("level hold within frame", int'(bus_if.level), cur_lvl, cur_lvl);
`ifndef ANFSQRT_PDM_DITHER_EN
            if (cur_lvl == 64 && pos >= 2)
               chk("T2 level 64 alternation", int'(bus_if.pdm_out), 1 - prev_pdm, 1 - prev_pdm);
`endif
            if (bus_if.overrun) begin
               if (ov_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected overrun: got pulse at cnt %0d, want none", pos);
               end else begin
                  oe = ov_q.pop_front();
                  chk({oe.name, " overrun position"}, pos, oe.pos, oe.pos);
               end
            end
         end
         prev_pdm = int'(bus_if.pdm_out);
      end
   end

   // Stimulus: directed vectors with hand-computed expectations.
   initial begin : stimulus
      rst_n             = 1'b0;
      bus_if.result     = '0;
      bus_if.result_vld = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk_reset_outputs("T1 power-on");

      push_fs(0, 0, "T1 first frame");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_fs();

      // T2 density for 64, 1 and 127 (loaded mid-frame, applied at wrap).
      push_fs(64, 0, "T2 load 64");
      vld_at(5, 64);
      wait_fs();
      push_fs(1, 64, "T2 load 1");
      vld_at(3, 1);
      wait_fs();
      push_fs(127, 1, "T2 load 127");
      vld_at(100, 127);
      wait_fs();

      // T3 word at cnt 5 held back until the wrap.
      push_fs(10, 127, "T3 boundary hold");
      vld_at(5, 10);
      wait_fs();

      // T4 second word before the boundary overruns; newest word wins.
      push_fs(30, 10, "T4 newest wins");
      push_ov(17, "T4");
      vld_at(8, 20);
      vld_at(16, 30);
      wait_fs();

      // T5 word on the wrap cycle bypasses a full buffer without overrun.
      push_fs(99, 30, "T5 coincidence");
      vld_at(50, 40);
      vld_at(127, 99);
      wait_fs();
      push_fs(99, 99, "T5 buffer cleared");
      wait_fs();

      // Repeated overruns in one frame.
      push_fs(7, 99, "multi overrun");
      push_ov(19, "multi second word");
      push_ov(27, "multi third word");
      vld_at(10, 5);
      vld_at(18, 6);
      vld_at(26, 7);
      wait_fs();

      // T1 mid-frame reset with a word pending: pending word is discarded.
      vld_at(20, 50);
      repeat (40 - spos) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      chk_reset_outputs("T1 mid-frame");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int f = 0; f < 3; f++) begin
         push_fs(0, 0, "T1 hold after reset");
         wait_fs();
      end

      repeat (5) @(negedge clk);
      chk("frame_start expectations drained", fs_q.size(), 0, 0);
      chk("overrun expectations drained",     ov_q.size(), 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no completion by 200000, want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
